// File: rtl/divider_seq_ctrl.sv
// Sequencer and remainder datapath for a WIDTH-cycle restoring unsigned divider.
// Steers an external quotient shift register through q_load_o / q_mux_o.
module divider_seq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             q_load_o,
  output logic [1:0]       q_mux_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [1:0] MUX_HOLD = 2'b00;
  localparam logic [1:0] MUX_SHL0 = 2'b01;
  localparam logic [1:0] MUX_SHL1 = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_ITER  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;

  // Restoring step: rem < dsr, so the low WIDTH bits of the difference are exact.
  logic [WIDTH:0]   trial;
  logic             trial_ge;
  logic [WIDTH-1:0] trial_diff;

  assign trial      = {rem_q, dvd_q[WIDTH-1]};
  assign trial_ge   = (trial >= {1'b0, dsr_q});
  assign trial_diff = trial[WIDTH-1:0] - dsr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    cnt_d    = cnt_q;
    dz_d     = dz_q;
    q_load_o = 1'b0;
    q_mux_o  = MUX_HOLD;
    busy_o   = 1'b0;
    done_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          dvd_d   = dividend_i;
          dsr_d   = divisor_i;
          rem_d   = '0;
          cnt_d   = CW'(WIDTH - 1);
          dz_d    = 1'b0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        q_load_o = 1'b1;
        busy_o   = 1'b1;
        if (dsr_q == '0) begin
          rem_d   = dvd_q;
          dz_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        busy_o = 1'b1;
        if (trial_ge) begin
          rem_d   = trial_diff;
          q_mux_o = MUX_SHL1;
        end else begin
          rem_d   = trial[WIDTH-1:0];
          q_mux_o = MUX_SHL0;
        end
        dvd_d = dvd_q << 1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign div_zero_o  = dz_q;
  assign remainder_o = rem_q;

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// Bench for divider_seq_ctrl: models the external quotient register and predicts
// every output per cycle from plain a/b arithmetic, plus directed literal checks.
module tb_divider_seq_ctrl;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_i;
  logic [W-1:0]  dividend_i, divisor_i;
  logic          q_load_o;
  logic [1:0]    q_mux_o;
  logic          busy_o, done_o, div_zero_o;
  logic [W-1:0]  remainder_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  divider_seq_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .q_load_o    (q_load_o),
    .q_mux_o     (q_mux_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .div_zero_o  (div_zero_o),
    .remainder_o (remainder_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External quotient shift register (no reset).
  logic [W-1:0] qreg;
  always @(posedge clk) begin
    if (q_load_o)              qreg <= '0;
    else if (q_mux_o == 2'b01) qreg <= {qreg[W-2:0], 1'b0};
    else if (q_mux_o == 2'b10) qreg <= {qreg[W-2:0], 1'b1};
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Cycle model: op accepted in cycle c0 -> CLEAR c0+1, ITER c0+2..c0+W+1, DONE c0+W+2.
  logic         m_active = 1'b0;
  logic         m_have_q = 1'b0;
  int           m_c0, m_cdone;
  logic [W-1:0] m_a, m_b, m_q, m_r, h_q, h_r;
  logic         m_dz, h_dz;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", 64'(busy_o), 64'(0));
      chk("rst_done", 64'(done_o), 64'(0));
      chk("rst_qload", 64'(q_load_o), 64'(0));
      chk("rst_qmux", 64'(q_mux_o), 64'(0));
      chk("rst_dz", 64'(div_zero_o), 64'(0));
      chk("rst_rem", 64'(remainder_o), 64'(0));
      m_active = 1'b0;
      m_have_q = 1'b0;
      h_r      = '0;
      h_dz     = 1'b0;
    end else begin
      if (m_active) begin
        logic [1:0] exp_mux;
        exp_mux = 2'b00;
        if (m_b != 0 && cyc >= m_c0 + 2 && cyc <= m_c0 + int'(W) + 1)
          exp_mux = m_q[int'(W) - 1 - (cyc - m_c0 - 2)] ? 2'b10 : 2'b01;
        chk("busy", 64'(busy_o), 64'(cyc > m_c0 && cyc < m_cdone));
        chk("done", 64'(done_o), 64'(cyc == m_cdone));
        chk("q_load", 64'(q_load_o), 64'(cyc == m_c0 + 1));
        chk("q_mux", 64'(q_mux_o), 64'(exp_mux));
        chk("div_zero", 64'(div_zero_o), 64'((cyc == m_cdone) ? m_dz : 1'b0));
        if (cyc == m_cdone) begin
          chk("quotient", 64'(qreg), 64'(m_q));
          chk("remainder", 64'(remainder_o), 64'(m_r));
          h_q = m_q; h_r = m_r; h_dz = m_dz;
          m_have_q = 1'b1;
          m_active = 1'b0;
        end
      end else begin
        chk("idle_busy", 64'(busy_o), 64'(0));
        chk("idle_done", 64'(done_o), 64'(0));
        chk("idle_qload", 64'(q_load_o), 64'(0));
        chk("idle_qmux", 64'(q_mux_o), 64'(0));
        chk("hold_rem", 64'(remainder_o), 64'(h_r));
        chk("hold_dz", 64'(div_zero_o), 64'(h_dz));
        if (m_have_q) chk("hold_q", 64'(qreg), 64'(h_q));
        if (start_i) begin
          m_active = 1'b1;
          m_c0 = cyc;
          m_a  = dividend_i;
          m_b  = divisor_i;
          m_q  = (m_b == 0) ? '0 : m_a / m_b;
          m_r  = (m_b == 0) ? m_a : m_a % m_b;
          m_dz = (m_b == 0);
          m_cdone = cyc + ((m_b == 0) ? 2 : int'(W) + 2);
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, output int c0);
    @(posedge clk); #1;
    dividend_i = a; divisor_i = b; start_i = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    start_i = 1'b0;
    dividend_i = ~a; divisor_i = ~b;
  endtask

  task automatic wait_done(input int c0, output int lat, output int n_load, output int n_shl0);
    logic seen;
    seen = 1'b0; lat = -1; n_load = 0; n_shl0 = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_load += int'(q_load_o);
      n_shl0 += int'(q_mux_o == 2'b01);
      if (done_o) begin
        seen = 1'b1;
        lat  = cyc - c0;
        break;
      end
    end
    chk("done_seen", 64'(seen), 64'(1));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input int elat, input logic edz, output int n_load, output int n_shl0);
    int c0, lat;
    issue(a, b, c0);
    wait_done(c0, lat, n_load, n_shl0);
    chk("lit_latency", 64'(lat), 64'(elat));
    chk("lit_quotient", 64'(qreg), 64'(eq));
    chk("lit_remainder", 64'(remainder_o), 64'(er));
    chk("lit_div_zero", 64'(div_zero_o), 64'(edz));
  endtask

  initial begin
    int nl, n0, c0, lat;
    rst_n = 1'b0; start_i = 1'b0; dividend_i = '0; divisor_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lit_reset_busy", 64'(busy_o), 64'(0));
    chk("lit_reset_rem", 64'(remainder_o), 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    run_op(32'd100, 32'd7, 32'd14, 32'd2, 34, 1'b0, nl, n0);
    run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 34, 1'b0, nl, n0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 34, 1'b0, nl, n0);
    run_op(32'd3, 32'd10, 32'd0, 32'd3, 34, 1'b0, nl, n0);
    chk("lit_shl0_count", 64'(n0), 64'(32));
    run_op(32'd5, 32'd0, 32'd0, 32'd5, 2, 1'b1, nl, n0);
    chk("lit_qload_count", 64'(nl), 64'(1));
    repeat (3) @(posedge clk);

    // Stray start during ITER cycle 5 must be ignored.
    issue(32'd1000000, 32'd77, c0);
    repeat (5) @(posedge clk);
    #1 dividend_i = 32'd9; divisor_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    wait_done(c0, lat, nl, n0);
    chk("lit_ign_latency", 64'(lat), 64'(34));
    chk("lit_ign_quotient", 64'(qreg), 64'(12987));
    chk("lit_ign_remainder", 64'(remainder_o), 64'(1));
    run_op(32'd9, 32'd3, 32'd3, 32'd0, 34, 1'b0, nl, n0);

    // Reset during ITER cycle 10.
    issue(32'd100, 32'd7, c0);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("lit_abort_busy", 64'(busy_o), 64'(0));
    chk("lit_abort_done", 64'(done_o), 64'(0));
    chk("lit_abort_rem", 64'(remainder_o), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(32'd1000, 32'd33, 32'd30, 32'd10, 34, 1'b0, nl, n0);
    repeat (4) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
